// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction memory port, IF/ID register out.
interface fetch_if #(
  parameter int WIDTH            = 32,
  parameter int INSTRUCTIONWIDTH = 24
) ();
  logic                        stall;
  logic                        branch_taken;
  logic [WIDTH-1:0]            branch_target;
  logic [WIDTH-1:0]            imem_addr;
  logic [INSTRUCTIONWIDTH-1:0] imem_rdata;
  logic [INSTRUCTIONWIDTH-1:0] instr_d;
  logic [WIDTH-1:0]            pc_d;
  logic [WIDTH-1:0]            pcplus_d;
  logic                        valid_d;
  logic                        halted;
  logic                        fault;

  // master is the fetch unit itself
  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, instr_d, pc_d, pcplus_d, valid_d, halted, fault
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, instr_d, pc_d, pcplus_d, valid_d, halted, fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction port combinationally
// and fills the IF/ID register, with stall, branch flush, halt and out-of-segment fault.
module fetch_unit #(
  parameter int                            WIDTH            = 32,
  parameter int                            INSTRUCTIONWIDTH = 24,
  parameter logic [WIDTH-1:0]              RESETPC          = '0,
  parameter int                            PCSTEP           = 1,
  parameter logic [INSTRUCTIONWIDTH-1:0]   HALTOP           = 24'hFFFFFF,
  parameter int                            IMEMLIMIT        = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HALT, S_FAULT} state_t;

  state_t                      state_q, state_d;
  logic [WIDTH-1:0]            pc_q, pc_d;
  logic [INSTRUCTIONWIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [WIDTH-1:0]            ifid_pc_q, ifid_pc_d;
  logic [WIDTH-1:0]            ifid_pcplus_q, ifid_pcplus_d;
  logic                        ifid_valid_q, ifid_valid_d;

  logic [WIDTH-1:0] pc_plus;
  logic             pc_oob;
  logic             is_haltop;

  assign pc_plus   = pc_q + WIDTH'(PCSTEP);
  assign pc_oob    = (pc_q >= WIDTH'(IMEMLIMIT));
  assign is_haltop = (bus.imem_rdata == HALTOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: begin
        if (bus.branch_taken)  state_d = S_FETCH;
        else if (bus.stall)    state_d = S_FETCH;
        else if (pc_oob)       state_d = S_FAULT;
        else if (is_haltop)    state_d = S_HALT;
      end
      S_HALT, S_FAULT: begin
        if (bus.branch_taken)  state_d = S_FETCH;
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    bus.halted = (state_q == S_HALT);
    bus.fault  = (state_q == S_FAULT);
  end

  // PC and IF/ID next-state; halt and fault keep the PC parked on the offending word
  always_comb begin
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_pcplus_d = ifid_pcplus_q;
    ifid_valid_d  = ifid_valid_q;
    unique case (state_q)
      S_BOOT: begin
        ifid_valid_d = 1'b0;
      end
      S_FETCH: begin
        if (bus.branch_taken) begin
          pc_d         = bus.branch_target;
          ifid_valid_d = 1'b0;
          ifid_instr_d = '0;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (pc_oob) begin
          ifid_valid_d = 1'b0;
        end else begin
          ifid_instr_d  = bus.imem_rdata;
          ifid_pc_d     = pc_q;
          ifid_pcplus_d = pc_plus;
          ifid_valid_d  = 1'b1;
          if (!is_haltop) pc_d = pc_plus;
        end
      end
      S_HALT, S_FAULT: begin
        if (bus.branch_taken) begin
          pc_d         = bus.branch_target;
          ifid_valid_d = 1'b0;
          ifid_instr_d = '0;
        end else if (!bus.stall) begin
          ifid_valid_d = 1'b0;
        end
      end
      default: begin
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESETPC;
      ifid_instr_q  <= '0;
      ifid_pc_q     <= '0;
      ifid_pcplus_q <= '0;
      ifid_valid_q  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_pcplus_q <= ifid_pcplus_d;
      ifid_valid_q  <= ifid_valid_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.instr_d   = ifid_instr_q;
  assign bus.pc_d      = ifid_pc_q;
  assign bus.pcplus_d  = ifid_pcplus_q;
  assign bus.valid_d   = ifid_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;

  localparam int WIDTH = 32;
  localparam int IW    = 24;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [IW-1:0] mem [32];

  fetch_if #(.WIDTH(WIDTH), .INSTRUCTIONWIDTH(IW)) bus ();

  fetch_unit #(
    .WIDTH(WIDTH), .INSTRUCTIONWIDTH(IW), .RESETPC('0), .PCSTEP(1),
    .HALTOP(24'hFFFFFF), .IMEMLIMIT(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_rdata = (bus.imem_addr < 32) ? mem[bus.imem_addr[4:0]] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic valid, input logic [31:0] addr);
    check({tag, ".instr"}, 32'(bus.instr_d), instr);
    check({tag, ".pc_d"},  bus.pc_d, pc);
    check({tag, ".valid"}, 32'(bus.valid_d), 32'(valid));
    check({tag, ".addr"},  bus.imem_addr, addr);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) mem[i] = IW'(i + 1);
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;

    // reset state
    #12;
    chk_ifid("rst", 32'h0, 32'h0, 1'b0, 32'h0);
    check("rst.pcplus", bus.pcplus_d, 32'h0);
    check("rst.halted", 32'(bus.halted), 32'h0);
    check("rst.fault",  32'(bus.fault), 32'h0);

    // test 1: boot then straight-line fetch
    #5 rst_n = 1'b1;
    step();
    chk_ifid("t1.boot", 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    chk_ifid("t1.c2", 32'h1, 32'h0, 1'b1, 32'h1);
    check("t1.c2.pcplus", bus.pcplus_d, 32'h1);
    step();
    chk_ifid("t1.c3", 32'h2, 32'h1, 1'b1, 32'h2);
    step();
    chk_ifid("t1.c4", 32'h3, 32'h2, 1'b1, 32'h3);

    // test 2: two-cycle stall at PC=3
    bus.stall = 1'b1;
    step();
    chk_ifid("t2.s1", 32'h3, 32'h2, 1'b1, 32'h3);
    step();
    chk_ifid("t2.s2", 32'h3, 32'h2, 1'b1, 32'h3);
    bus.stall = 1'b0;
    step();
    chk_ifid("t2.rel", 32'h4, 32'h3, 1'b1, 32'h4);

    // test 3: branch beats stall
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'd8;
    step();
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    chk_ifid("t3.flush", 32'h0, 32'h3, 1'b0, 32'h8);
    step();
    chk_ifid("t3.tgt", 32'h9, 32'h8, 1'b1, 32'h9);

    // test 4: halt opcode at 5, stall in HALT, then branch out
    mem[5] = 24'hFFFFFF;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'd5;
    step();
    bus.branch_taken = 1'b0;
    chk_ifid("t4.br", 32'h0, 32'h8, 1'b0, 32'h5);
    step();
    chk_ifid("t4.hop", 32'hFFFFFF, 32'h5, 1'b1, 32'h5);
    check("t4.hop.pcplus", bus.pcplus_d, 32'h6);
    check("t4.hop.halted", 32'(bus.halted), 32'h1);
    bus.stall = 1'b1;
    step();
    chk_ifid("t4.hstall", 32'hFFFFFF, 32'h5, 1'b1, 32'h5);
    bus.stall = 1'b0;
    step();
    chk_ifid("t4.drain", 32'hFFFFFF, 32'h5, 1'b0, 32'h5);
    check("t4.drain.halted", 32'(bus.halted), 32'h1);
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'd2;
    step();
    bus.branch_taken = 1'b0;
    check("t4.esc.halted", 32'(bus.halted), 32'h0);
    check("t4.esc.addr", bus.imem_addr, 32'h2);
    step();
    chk_ifid("t4.resume", 32'h3, 32'h2, 1'b1, 32'h3);
    mem[5] = 24'h000006;

    // test 5: run off the end of the instruction segment
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'd12;
    step();
    bus.branch_taken = 1'b0;
    check("t5.br.addr", bus.imem_addr, 32'hC);
    for (int k = 12; k < 16; k++) begin
      step();
      chk_ifid($sformatf("t5.pc%0d", k), 32'(k + 1), 32'(k), 1'b1, 32'(k + 1));
      check($sformatf("t5.pc%0d.fault", k), 32'(bus.fault), 32'h0);
    end
    step();
    check("t5.fault", 32'(bus.fault), 32'h1);
    check("t5.fault.valid", 32'(bus.valid_d), 32'h0);
    check("t5.fault.addr", bus.imem_addr, 32'h10);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("t5.hold%0d.addr", k), bus.imem_addr, 32'h10);
      check($sformatf("t5.hold%0d.fault", k), 32'(bus.fault), 32'h1);
    end
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'd7;
    step();
    bus.branch_taken = 1'b0;
    check("t5.esc.fault", 32'(bus.fault), 32'h0);
    check("t5.esc.addr", bus.imem_addr, 32'h7);
    step();
    chk_ifid("t5.resume", 32'h8, 32'h7, 1'b1, 32'h8);

    // test 6: asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    chk_ifid("t6.rst", 32'h0, 32'h0, 1'b0, 32'h0);
    check("t6.rst.pcplus", bus.pcplus_d, 32'h0);
    #2 rst_n = 1'b1;
    step();
    chk_ifid("t6.boot", 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    chk_ifid("t6.first", 32'h1, 32'h0, 1'b1, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
